// File: rtl/adder_tree_complex_pkg.sv
// adder_tree_complex_pkg
// Shared constants and helpers for the pipelined N-input complex adder tree.
//   N_MIN / N_MAX  : legal range of the number of summed inputs
//   FMT_WIDTH      : width of the generic signed container used by the
//                    range-check and formatting helpers
//   tree_levels    : ceil(log2(n)), never less than 1
//   level_count    : number of values alive after a given tree level
//   is_out_of_range: exact sum outside the signed w-bit range
//   sat_wrap       : saturate (sat_en=1) or two's-complement wrap (sat_en=0)
package adder_tree_complex_pkg;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 16;
    localparam int FMT_WIDTH = 64;

    // Number of pairwise-add levels needed to reduce n values to one.
    function automatic int tree_levels(input int n);
        int l;
        l = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << l) < n) begin
                l = l + 1;
            end
        end
        if (l < 1) begin
            l = 1;
        end
        return l;
    endfunction

    // Values remaining after lvl levels: an odd leftover is carried forward.
    function automatic int level_count(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    // The caller sign-extends its WI-bit exact sum into FMT_WIDTH bits.
    function automatic logic is_out_of_range(input logic signed [FMT_WIDTH-1:0] value,
                                             input int w);
        logic signed [FMT_WIDTH-1:0] max_v;
        logic signed [FMT_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        return (value > max_v) || (value < min_v);
    endfunction

    // Result in the low w bits; the caller truncates to its W-bit output.
    function automatic logic [FMT_WIDTH-1:0] sat_wrap(input logic signed [FMT_WIDTH-1:0] value,
                                                      input int w,
                                                      input logic sat_en);
        logic signed [FMT_WIDTH-1:0] max_v;
        logic signed [FMT_WIDTH-1:0] min_v;
        logic [FMT_WIDTH-1:0]        res;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (sat_en && (value > max_v)) begin
            res = max_v;
        end else if (sat_en && (value < min_v)) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level
// One registered level of the adder tree: M signed WI-bit values in,
// ceil(M/2) pairwise sums out. An odd last element passes through.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   advance   : pipeline may move this cycle
//   valid     : the data at in_data belongs to a real beat
//   in_data   : M packed values, element k at [k*WI +: WI]
//   out_data  : ceil(M/2) registered values, same packing
module adder_tree_level
    import adder_tree_complex_pkg::*;
#(
    parameter int M  = 3,
    parameter int WI = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  advance,
    input  logic                                  valid,
    input  logic [M*WI-1:0]                       in_data,
    output logic [level_count(M, 1)*WI-1:0]       out_data
);

    localparam int MO = level_count(M, 1);

    logic [MO*WI-1:0] sum_s;

    for (genvar k = 0; k < MO; k++) begin : gen_pair
        if (2 * k + 1 < M) begin : g_add
            // WI already has headroom for the whole tree, so no wrap here.
            assign sum_s[k*WI +: WI] = $signed(in_data[2*k*WI +: WI])
                                     + $signed(in_data[(2*k+1)*WI +: WI]);
        end else begin : g_pass
            assign sum_s[k*WI +: WI] = in_data[2*k*WI +: WI];
        end
    end

    // Level register: loads only real beats, holds on stall and on bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (advance && valid) begin
            out_data <= sum_s;
        end
    end

endmodule

// File: rtl/adder_tree_complex.sv
// adder_tree_complex
// Pipelined N-input complex adder for signed Q(QI.QF) samples. Each tree
// level is registered, followed by one range-check/format stage, so latency
// is tree_levels(N)+1 cycles. A single global stall freezes every stage.
// Build option: define ADDER_TREE_COMPLEX_SAT_EN to saturate overflowing
// components; otherwise they wrap to the low W bits.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = !out_valid | out_ready)
//   in_re, in_im        : N packed W-bit operands, element k at [k*W +: W]
//   out_valid/out_ready : output handshake
//   out_re, out_im      : W-bit sum
//   out_ovf             : this beat's Re or Im exact sum exceeded W bits
//   ovf_sticky, ovf_clr : latched overflow flag and its synchronous clear
module adder_tree_complex
    import adder_tree_complex_pkg::*;
#(
    parameter int QI = 4,
    parameter int QF = 4,
    parameter int N  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*(QI+QF)-1:0]   in_re,
    input  logic [N*(QI+QF)-1:0]   in_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [QI+QF-1:0]       out_re,
    output logic [QI+QF-1:0]       out_im,
    output logic                   out_ovf,
    output logic                   ovf_sticky,
    input  logic                   ovf_clr
);

    localparam int W  = QI + QF;
    localparam int L  = tree_levels(N);
    localparam int WI = W + L;

`ifdef ADDER_TREE_COMPLEX_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
        $error("adder_tree_complex: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
    end

    logic                 advance_s;
    logic [L-1:0]         valid_r;
    logic [N*WI-1:0]      re_ext_s;
    logic [N*WI-1:0]      im_ext_s;
    logic signed [WI-1:0] sum_re_s;
    logic signed [WI-1:0] sum_im_s;
    logic [W-1:0]         re_fmt_s;
    logic [W-1:0]         im_fmt_s;
    logic                 ovf_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < N; k++) begin : gen_ext
        assign re_ext_s[k*WI +: WI] = WI'($signed(in_re[k*W +: W]));
        assign im_ext_s[k*WI +: WI] = WI'($signed(in_im[k*W +: W]));
    end

    for (genvar g = 0; g < L; g++) begin : gen_lvl
        localparam int MI = level_count(N, g);
        localparam int MO = level_count(N, g + 1);

        logic              lvl_valid_s;
        logic [MI*WI-1:0]  re_i;
        logic [MI*WI-1:0]  im_i;
        logic [MO*WI-1:0]  re_o;
        logic [MO*WI-1:0]  im_o;

        if (g == 0) begin : g_first
            assign lvl_valid_s = in_valid;
            assign re_i        = re_ext_s;
            assign im_i        = im_ext_s;
        end else begin : g_next
            assign lvl_valid_s = valid_r[g-1];
            assign re_i        = gen_lvl[g-1].re_o;
            assign im_i        = gen_lvl[g-1].im_o;
        end

        adder_tree_level #(.M(MI), .WI(WI)) u_re (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance_s),
            .valid    (lvl_valid_s),
            .in_data  (re_i),
            .out_data (re_o)
        );

        adder_tree_level #(.M(MI), .WI(WI)) u_im (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance_s),
            .valid    (lvl_valid_s),
            .in_data  (im_i),
            .out_data (im_o)
        );
    end

    assign sum_re_s = gen_lvl[L-1].re_o;
    assign sum_im_s = gen_lvl[L-1].im_o;

    // Range check and formatting of the exact tree result.
    always_comb begin
        re_fmt_s = W'(sat_wrap(FMT_WIDTH'(sum_re_s), W, SAT_EN));
        im_fmt_s = W'(sat_wrap(FMT_WIDTH'(sum_im_s), W, SAT_EN));
        ovf_s    = is_out_of_range(FMT_WIDTH'(sum_re_s), W)
                 | is_out_of_range(FMT_WIDTH'(sum_im_s), W);
    end

    // Valid chain shared by the Re and Im trees; bubbles keep their slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (advance_s) begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < L; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Output stage: data only reloads for real beats so it stays stable on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_ovf   <= 1'b0;
        end else if (advance_s) begin
            out_valid <= valid_r[L-1];
            if (valid_r[L-1]) begin
                out_re  <= re_fmt_s;
                out_im  <= im_fmt_s;
                out_ovf <= ovf_s;
            end
        end
    end

    // Sticky overflow: an overflowing transfer beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_complex.sv
module tb_adder_tree_complex;

    typedef struct {
        logic [7:0] re;
        logic [7:0] im;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clr;
    logic [31:0] in_re;
    logic [31:0] in_im;

    logic        in_ready_a   [2];
    logic        out_valid_a  [2];
    logic [7:0]  out_re_a     [2];
    logic [7:0]  out_im_a     [2];
    logic        out_ovf_a    [2];
    logic        ovf_sticky_a [2];

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   [2];

    exp_t exp_q [2][$];
    logic sticky_m    [2];
    logic stalled_prev[2];
    logic [7:0] prev_re [2];
    logic [7:0] prev_im [2];
    logic       prev_ovf[2];

    always #5 clk = ~clk;

    adder_tree_complex #(.QI(4), .QF(4), .N(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[0]),
        .in_re(in_re[23:0]), .in_im(in_im[23:0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready),
        .out_re(out_re_a[0]), .out_im(out_im_a[0]), .out_ovf(out_ovf_a[0]),
        .ovf_sticky(ovf_sticky_a[0]), .ovf_clr(ovf_clr)
    );

    adder_tree_complex #(.QI(4), .QF(4), .N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[1]),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid_a[1]), .out_ready(out_ready),
        .out_re(out_re_a[1]), .out_im(out_im_a[1]), .out_ovf(out_ovf_a[1]),
        .ovf_sticky(ovf_sticky_a[1]), .ovf_clr(ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fmt(input int s);
`ifdef ADDER_TREE_COMPLEX_SAT_EN
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return s[7:0];
    endfunction

    // Exact integer sum of the first n signed bytes, then range rule.
    function automatic exp_t model(input logic [31:0] re, input logic [31:0] im, input int n);
        exp_t e;
        int sr = 0;
        int si = 0;
        for (int k = 0; k < n; k++) begin
            sr += int'($signed(re[k*8 +: 8]));
            si += int'($signed(im[k*8 +: 8]));
        end
        e.re  = fmt(sr);
        e.im  = fmt(si);
        e.ovf = (sr > 127) || (sr < -128) || (si > 127) || (si < -128);
        return e;
    endfunction

    // Scoreboard: checks every cycle, then predicts the next edge's transfers.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_q[d].delete();
                sticky_m[d]     = 1'b0;
                stalled_prev[d] = 1'b0;
                check($sformatf("dut%0d_rst_valid", d), out_valid_a[d], 1'b0);
            end else begin
                check($sformatf("dut%0d_in_ready", d), in_ready_a[d],
                      !out_valid_a[d] || out_ready);
                check($sformatf("dut%0d_sticky", d), ovf_sticky_a[d], sticky_m[d]);
                if (stalled_prev[d]) begin
                    check($sformatf("dut%0d_hold_valid", d), out_valid_a[d], 1'b1);
                    check($sformatf("dut%0d_hold_re", d), out_re_a[d], prev_re[d]);
                    check($sformatf("dut%0d_hold_im", d), out_im_a[d], prev_im[d]);
                    check($sformatf("dut%0d_hold_ovf", d), out_ovf_a[d], prev_ovf[d]);
                end
                if (out_valid_a[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("dut%0d_unexpected_beat", d), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("dut%0d_re", d), out_re_a[d], exp_q[d][0].re);
                        check($sformatf("dut%0d_im", d), out_im_a[d], exp_q[d][0].im);
                        check($sformatf("dut%0d_ovf", d), out_ovf_a[d], exp_q[d][0].ovf);
                        if (out_ready) begin
                            if (exp_q[d][0].ovf) sticky_m[d] = 1'b1;
                            else if (ovf_clr) sticky_m[d] = 1'b0;
                            void'(exp_q[d].pop_front());
                            n_out[d]++;
                        end else if (ovf_clr) begin
                            sticky_m[d] = 1'b0;
                        end
                    end
                end else if (ovf_clr) begin
                    sticky_m[d] = 1'b0;
                end
                if (in_valid && in_ready_a[d]) begin
                    exp_q[d].push_back(model(in_re, in_im, d == 0 ? 3 : 4));
                end
                stalled_prev[d] = out_valid_a[d] && !out_ready;
                prev_re[d]  = out_re_a[d];
                prev_im[d]  = out_im_a[d];
                prev_ovf[d] = out_ovf_a[d];
            end
        end
    end

    // Present one beat (entered just after a posedge), return just after its transfer edge.
    task automatic send(input logic [31:0] re, input logic [31:0] im);
        int b = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        @(negedge clk);
        while (!in_ready_a[0] && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("send_accept_timeout", (b < 50), 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send a beat, measure latency, check N=3 outputs against literals, let it drain.
    task automatic run_lat(input string name, input logic [31:0] re, input logic [31:0] im,
                           input logic [7:0] exp_re, input logic [7:0] exp_im, input logic exp_ovf);
        int n = 0;
        send(re, im);
        while (!out_valid_a[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency3"}, n + 1, 3);
        check({name, "_latency4"}, out_valid_a[1], 1'b1);
        check({name, "_re"}, out_re_a[0], exp_re);
        check({name, "_im"}, out_im_a[0], exp_im);
        check({name, "_ovf"}, out_ovf_a[0], exp_ovf);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] beats_re [20];
    logic [31:0] beats_im [20];

    initial begin
        exp_t m;
        int   i;
        int   j;
        int   k;
        int   base;
        n_out[0] = 0;
        n_out[1] = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        in_re     = 32'h0;
        in_im     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid_a[0], 1'b0);
        check("reset_in_ready", in_ready_a[0], 1'b1);
        check("reset_sticky", ovf_sticky_a[0], 1'b0);
        check("reset_out_re", out_re_a[0], 8'h00);
        check("reset_out_ovf", out_ovf_a[1], 1'b0);
        @(posedge clk);
        #1;

        // Pin the model with hand-derived sums.
        m = model(32'h00040112, 32'h00030603, 3);
        check("model_basic_re", m.re, 8'h17);
        check("model_basic_im", m.im, 8'h0C);
        m = model(32'h00707070, 32'h0, 3);
        check("model_posovf_ovf", m.ovf, 1'b1);
`ifdef ADDER_TREE_COMPLEX_SAT_EN
        check("model_posovf_re", m.re, 8'h7F);
`else
        check("model_posovf_re", m.re, 8'h50);
`endif
        m = model(32'h05040302, 32'h0, 4);
        check("model_n4_re", m.re, 8'h0E);

        run_lat("basic", 32'h00040112, 32'h00030603, 8'h17, 8'h0C, 1'b0);
        check("basic_dut4_sticky", ovf_sticky_a[1], 1'b0);
        run_lat("mixed", 32'h00FF01FD, 32'h00FF01FE, 8'hFD, 8'hFE, 1'b0);
`ifdef ADDER_TREE_COMPLEX_SAT_EN
        run_lat("posovf", 32'h00707070, 32'h0, 8'h7F, 8'h00, 1'b1);
`else
        run_lat("posovf", 32'h00707070, 32'h0, 8'h50, 8'h00, 1'b1);
`endif
        check("posovf_sticky", ovf_sticky_a[0], 1'b1);
`ifdef ADDER_TREE_COMPLEX_SAT_EN
        run_lat("negovf", 32'h00909090, 32'h0, 8'h80, 8'h00, 1'b1);
`else
        run_lat("negovf", 32'h00909090, 32'h0, 8'hB0, 8'h00, 1'b1);
`endif
        check("negovf_sticky", ovf_sticky_a[0], 1'b1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check("clr_sticky3", ovf_sticky_a[0], 1'b0);
        check("clr_sticky4", ovf_sticky_a[1], 1'b0);

        // Random stream with a 5-cycle output stall in the middle.
        for (int b = 0; b < 20; b++) begin
            beats_re[b] = $urandom;
            beats_im[b] = $urandom;
        end
        base = n_out[1];
        i = 0;
        j = 0;
        while (i < 20 && j < 200) begin
            @(posedge clk);
            #1;
            out_ready = !(j >= 6 && j < 11);
            in_valid  = 1'b1;
            in_re     = beats_re[i];
            in_im     = beats_im[i];
            @(negedge clk);
            if (in_ready_a[0]) i++;
            j++;
        end
        check("stream_accept_timeout", (j < 200), 1'b1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && k < 50) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("stream_drain_timeout", (k < 50), 1'b1);
        check("stream_count", n_out[1] - base, 20);

        // Reset with three beats in flight.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_re = 32'h01010101 * (b + 1);
            in_im = 32'h0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid_a[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_out_valid3", out_valid_a[0], 1'b0);
        check("rst_out_valid4", out_valid_a[1], 1'b0);
        check("rst_in_ready", in_ready_a[0], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_lat("after_rst", 32'h04030201, 32'h10101010, 8'h06, 8'h30, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("final_queue3_empty", exp_q[0].size(), 0);
        check("final_queue4_empty", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_tree_complex.md
# adder_tree_complex

Pipelined, parametrised N-input complex fixed-point adder for signed Q(QI.QF) operands, generalising the combinational three-input complex adder. It sums N complex samples per beat through a registered binary adder tree with full internal precision and produces per-beat and sticky overflow status. It sits in the convolution datapath after the complex multipliers, accumulating kernel-tap products, with valid/ready flow control on both sides.

## Interface
- QI, 4, integer bits of operands and result, sign included
- QF, 4, fractional bits
- N, 3, number of complex inputs summed per beat; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_re  input  N*(QI+QF)  real parts; element k at [k*W +: W], W=QI+QF
- in_im  input  N*(QI+QF)  imaginary parts, same packing
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_re  output  QI+QF  real part of the sum
- out_im  output  QI+QF  imaginary part of the sum
- out_ovf  output  1  this beat's Re or Im exact sum is outside the W-bit range
- ovf_sticky  output  1  set by any accepted beat with out_ovf=1
- ovf_clr  input  1  synchronous clear of ovf_sticky

## Operation
- Define L = ceil(log2(N)) and internal width WI = W + L; the internal sum is exact, so the tree never wraps.
- Inputs are sign-extended to WI. Each tree level adds adjacent pairs; an odd leftover element is passed to the next level unchanged. Every level is registered.
- The final stage compares the WI-bit sum against [-2^(W-1), 2^(W-1)-1] for Re and Im independently; out_ovf = ovf_re | ovf_im. The range check and result formatting form one additional registered stage.
- Re and Im are processed identically and in lockstep; the fractional point is unchanged (no rounding, no rescaling).
- ovf_sticky is set when a beat with out_ovf=1 is transferred (out_valid & out_ready). It is cleared by ovf_clr. If ovf_clr and a setting transfer coincide, set wins.

## Timing
- Latency: L+1 cycles from input transfer to out_valid, given no stall. N=2 gives 2; N=3 and N=4 give 3; N=16 gives 5.
- Throughput: one beat per cycle.
- Global stall: advance = !out_valid | out_ready, and in_ready = advance. While advance is 0, every pipeline register, including valid bits, holds.
- Bubbles are not collapsed. A stage with valid=0 still occupies its slot.
- out_re, out_im, and out_ovf are stable while out_valid=1 and out_ready=0.
- in_ready is combinational from out_valid and out_ready. It does not depend on in_valid.
- Reset: all valid bits, out_re, out_im, out_ovf, and ovf_sticky go to 0 immediately. in_ready is 1 after reset. In-flight beats are discarded, not flushed.
- A beat presented with in_valid=1 and in_ready=0 is not consumed. The source must hold it.

## Configuration
- ADDER_TREE_COMPLEX_SAT_EN defined: an overflowing component saturates to 2^(W-1)-1 if positive or -2^(W-1) if negative.
- ADDER_TREE_COMPLEX_SAT_EN undefined: each component is the low W bits of the exact sum (two's-complement wrap).
- out_ovf and ovf_sticky behave identically in both builds.

## Structure
- Package adder_tree_complex_pkg holds:
  - the levels function (ceil log2, minimum 1),
  - the saturate/wrap function parametrised on WI and W,
  - the legal N bounds.
- One sub-module, adder_tree_level: a single registered level taking M signed WI-bit values and producing ceil(M/2) values, with valid and advance. The top generates L instances for Re and for Im, plus a shared valid chain.
- An elaboration-time check rejects N outside 2..16.

## Test plan
- N=3, Q4.4 basic case:
  - Input: Re {0x12, 0x01, 0x04}, Im {0x03, 0x06, 0x03}, out_ready=1.
  - Expect: out_re=0x17, out_im=0x0C, out_ovf=0, out_valid exactly 3 cycles after transfer.
- N=3 mixed-sign case:
  - Input: Re {0xFD, 0x01, 0xFF}, Im {0xFE, 0x01, 0xFF}.
  - Expect: 0xFD / 0xFE, no overflow.
- N=3 positive overflow:
  - Input: Re {0x70, 0x70, 0x70}, Im all 0.
  - Expect: out_ovf=1 and ovf_sticky=1.
  - Expect out_re=0x7F with SAT_EN, 0x50 without.
- N=3 negative overflow and clear:
  - Input: Re {0x90, 0x90, 0x90}.
  - Expect out_re=0x80 with SAT_EN, 0xB0 without.
  - Assert ovf_clr for one cycle with no overflowing transfer: expect ovf_sticky=0 the next cycle.
- Backpressure (N=4, random stream of 20 beats):
  - Hold out_ready=0 for 5 cycles mid-stream.
  - Expect in_ready=0 while out_valid=1 and out_ready=0, outputs held stable, all 20 sums in order with none lost or duplicated.
- Reset mid-stream:
  - Assert rst with 3 beats in flight.
  - Expect out_valid=0 immediately.
  - After release, the next beat emerges after L+1 cycles with its correct sum.
